arp_result_dispatch: RTL and testbench
======================================

ARP_RESULT_DISPATCH -- requirements
Module: arp_result_dispatch

Interface
REQ-001 Parameter NUM_QUEUES, default 8: width of one-hot port vectors; MAC ports on even bits, CPU queues on odd bits.
REQ-002 Parameter CNT_WIDTH, default 32: width of each miss counter.
REQ-003 clk  in  1  sole clock; all state is on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 arp_mac_vld  in  1  ARP result FIFO non-empty.
REQ-006 next_hop_mac  in  48  ARP lookup MAC result.
REQ-007 output_port  in  NUM_QUEUES  one-hot port chosen by the LPM lookup.
REQ-008 arp_lookup_hit  in  1  ARP table hit.
REQ-009 lpm_lookup_hit  in  1  LPM table hit.
REQ-010 rd_arp_result  out  1  pop strobe to the ARP result FIFO.
REQ-011 src_vld  in  1  source-port FIFO non-empty.
REQ-012 src_port  in  NUM_QUEUES  one-hot ingress port of the packet.
REQ-013 rd_src  out  1  pop strobe to the source-port FIFO.
REQ-014 result_vld  out  1  decision valid.
REQ-015 result_rdy  in  1  consumer accepts the decision.
REQ-016 dst_mac  out  48  rewrite MAC.
REQ-017 dst_port  out  NUM_QUEUES  one-hot destination.
REQ-018 to_cpu  out  1  exception, sent to the CPU queue.
REQ-019 drop  out  1  discard the packet.
REQ-020 reason  out  2  00 = forward, 01 = LPM miss, 10 = ARP miss, 11 = exception from a CPU source.
REQ-021 lpm_miss_cnt, arp_miss_cnt  out  CNT_WIDTH  each  saturating miss counters.
REQ-022 cnt_clear  in  1  synchronous one-cycle clear of both counters.

Function
REQ-023 Join: a pop shall occur when arp_mac_vld, src_vld and (!result_vld or result_rdy) are all 1.
REQ-024 A pop shall assert rd_arp_result and rd_src together in that single cycle; neither strobe shall ever assert without the other.
REQ-025 Output register states: EMPTY and FULL.
- EMPTY -> FULL on a pop.
- FULL -> EMPTY on result_rdy with no pop.
- FULL stays FULL when result_rdy and a pop occur in the same cycle; a new decision is loaded.
- Throughput: one decision per cycle.
REQ-026 Latency: the decision is on the outputs, with result_vld = 1, in the cycle after the pop.
REQ-027 Outputs shall hold stable while result_vld = 1 and result_rdy = 0.
REQ-028 Decision priority:
- !lpm_lookup_hit -> reason 01.
- else !arp_lookup_hit -> reason 10.
- else reason 00: dst_port = output_port, dst_mac = next_hop_mac, to_cpu = 0, drop = 0.
REQ-029 Miss with src_port on an even bit 2i: dst_port = bit 2i+1 only, to_cpu = 1, drop = 0, dst_mac = 0.
REQ-030 Miss with src_port on an odd bit, or with src_port = 0: reason 11, dst_port = 0, drop = 1, to_cpu = 0. The LPM/ARP miss counters still count this miss.
REQ-031 On each pop, a reason-01 decision shall increment lpm_miss_cnt by 1 and a reason-10 decision shall increment arp_miss_cnt by 1; each counter saturates at all-ones.
REQ-032 cnt_clear shall take priority over an increment in the same cycle; both counters read 0 the next cycle.
REQ-033 A src_port with more than one bit set is a protocol violation; the lowest set bit shall be used.

Reset
REQ-034 Asserting reset shall immediately force the following to 0: result_vld, dst_mac, dst_port, to_cpu, drop, reason, both counters, rd_arp_result, rd_src.
REQ-035 Reset asserted mid-handshake shall discard the held decision; no pop shall occur while reset is asserted.
REQ-036 After reset release, the first pop shall occur no earlier than the first rising edge with reset high.

Structure
REQ-037 A shared package shall hold:
- reason encodings;
- CPU-queue mapping function (even bit 2i -> bit 2i+1);
- CNT_WIDTH default.
REQ-038 One sub-module, sat_counter (width-parameterized, increment/clear, saturating), instantiated twice.

Verification
REQ-039 Forward case: lpm hit, arp hit, output_port = 8'h04, MAC 48'h0011_2233_4455, src = 8'h01 -> next cycle result_vld = 1, dst_port = 8'h04, dst_mac = 48'h0011_2233_4455, reason 00.
REQ-040 ARP miss from src 8'h04 -> dst_port = 8'h08, to_cpu = 1, reason 10, arp_miss_cnt = 1.
REQ-041 LPM miss from src 8'h02 (CPU queue) -> drop = 1, dst_port = 0, reason 11, lpm_miss_cnt = 1.
REQ-042 Back-pressure: result_rdy = 0 for 5 cycles with both FIFOs holding 3 entries -> exactly one pop, outputs stable. Then result_rdy = 1 -> remaining 2 entries drain on consecutive cycles.
REQ-043 Saturation and clear: preload arp_miss_cnt to all-ones, then an ARP miss -> stays all-ones. cnt_clear coincident with a miss -> counter = 0.
REQ-044 Join skew: arp_mac_vld = 1 for 4 cycles before src_vld rises -> no pop and no strobes until src_vld = 1; an async reset during result_vld = 1 -> result_vld = 0 immediately.

Source files
------------

// File: rtl/arp_result_dispatch_pkg.sv
// Shared types and helpers for the ARP result dispatcher: reason codes,
// output-register states and the MAC-port to CPU-queue mapping.
package arp_result_dispatch_pkg;

    localparam int CNT_WIDTH_DEF = 32;
    localparam int MAC_WIDTH     = 48;

    typedef enum logic [1:0] {
        REASON_FWD      = 2'b00,
        REASON_LPM_MISS = 2'b01,
        REASON_ARP_MISS = 2'b10,
        REASON_CPU_EXC  = 2'b11
    } reason_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // MAC ports sit on even bits; each one's CPU queue is the odd bit just above it.
    function automatic int cpu_queue_of(input int mac_bit);
        return mac_bit | 1;
    endfunction

endpackage

// File: rtl/arp_result_dispatch_sat.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/arp_result_dispatch.sv
// Joins ARP lookup results with packet source ports and registers one
// forward/CPU/drop decision per cycle, with per-type miss counters.
//
//   state    | meaning
//   ST_EMPTY | no decision held, result_vld = 0
//   ST_FULL  | decision held on the outputs, result_vld = 1
module arp_result_dispatch
    import arp_result_dispatch_pkg::*;
#(
    parameter int NUM_QUEUES = 8,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arp_mac_vld,
    input  logic [MAC_WIDTH-1:0]  next_hop_mac,
    input  logic [NUM_QUEUES-1:0] output_port,
    input  logic                  arp_lookup_hit,
    input  logic                  lpm_lookup_hit,
    output logic                  rd_arp_result,
    input  logic                  src_vld,
    input  logic [NUM_QUEUES-1:0] src_port,
    output logic                  rd_src,
    output logic                  result_vld,
    input  logic                  result_rdy,
    output logic [MAC_WIDTH-1:0]  dst_mac,
    output logic [NUM_QUEUES-1:0] dst_port,
    output logic                  to_cpu,
    output logic                  drop,
    output logic [1:0]            reason,
    output logic [CNT_WIDTH-1:0]  lpm_miss_cnt,
    output logic [CNT_WIDTH-1:0]  arp_miss_cnt,
    input  logic                  cnt_clear
);

    out_state_e              state, state_nxt;
    logic                    pop;
    logic [NUM_QUEUES-1:0]   src_low;
    logic [NUM_QUEUES-1:0]   cpu_port;
    logic                    src_is_mac;
    logic [MAC_WIDTH-1:0]    nxt_mac;
    logic [NUM_QUEUES-1:0]   nxt_port;
    logic                    nxt_cpu;
    logic                    nxt_drop;
    reason_e                 nxt_reason;

    // Gating on reset keeps both FIFOs untouched while reset is held.
    assign pop           = reset & arp_mac_vld & src_vld & (~result_vld | result_rdy);
    assign rd_arp_result = pop;
    assign rd_src        = pop;
    assign result_vld    = (state == ST_FULL);

    // Multi-bit source vectors are reduced to their lowest set bit.
    assign src_low = src_port & (~src_port + NUM_QUEUES'(1));

    always_comb begin
        cpu_port   = '0;
        src_is_mac = 1'b0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (src_low[i] && !i[0] && (cpu_queue_of(i) < NUM_QUEUES)) begin
                cpu_port[cpu_queue_of(i)] = 1'b1;
                src_is_mac                = 1'b1;
            end
        end
    end

    always_comb begin
        nxt_mac    = '0;
        nxt_port   = '0;
        nxt_cpu    = 1'b0;
        nxt_drop   = 1'b0;
        nxt_reason = REASON_FWD;
        if (lpm_lookup_hit && arp_lookup_hit) begin
            nxt_mac  = next_hop_mac;
            nxt_port = output_port;
        end else if (src_is_mac) begin
            nxt_reason = lpm_lookup_hit ? REASON_ARP_MISS : REASON_LPM_MISS;
            nxt_port   = cpu_port;
            nxt_cpu    = 1'b1;
        end else begin
            nxt_reason = REASON_CPU_EXC;
            nxt_drop   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (pop) state_nxt = ST_FULL;
            ST_FULL: begin
                if (pop) begin
                    state_nxt = ST_FULL;
                end else if (result_rdy) begin
                    state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dst_mac  <= '0;
            dst_port <= '0;
            to_cpu   <= 1'b0;
            drop     <= 1'b0;
            reason   <= 2'b00;
        end else if (pop) begin
            dst_mac  <= nxt_mac;
            dst_port <= nxt_port;
            to_cpu   <= nxt_cpu;
            drop     <= nxt_drop;
            reason   <= nxt_reason;
        end
    end

    // Misses count by lookup outcome, including those dropped as CPU-source exceptions.
    sat_counter #(.WIDTH(CNT_WIDTH)) u_lpm_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (pop & ~lpm_lookup_hit),
        .count (lpm_miss_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_arp_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (pop & lpm_lookup_hit & ~arp_lookup_hit),
        .count (arp_miss_cnt)
    );

endmodule

// File: tb/tb_arp_result_dispatch.sv
// Self-checking bench for arp_result_dispatch: vector table plus hand-written
// back-pressure, saturation, join-skew and async-reset sequences.
module tb_arp_result_dispatch;

    localparam int NQ = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic [1:0]  reason;
        logic [7:0]  port;
        logic [47:0] mac;
        logic        cpu;
        logic        drop;
    } dec_t;

    typedef struct {
        logic        lpm;
        logic        arp;
        logic [7:0]  op;
        logic [47:0] mac;
        logic [7:0]  src;
        dec_t        exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          arp_mac_vld;
    logic [47:0]   next_hop_mac;
    logic [NQ-1:0] output_port;
    logic          arp_lookup_hit;
    logic          lpm_lookup_hit;
    logic          rd_arp_result;
    logic          src_vld;
    logic [NQ-1:0] src_port;
    logic          rd_src;
    logic          result_vld;
    logic          result_rdy;
    logic [47:0]   dst_mac;
    logic [NQ-1:0] dst_port;
    logic          to_cpu;
    logic          drop;
    logic [1:0]    reason;
    logic [CW-1:0] lpm_miss_cnt;
    logic [CW-1:0] arp_miss_cnt;
    logic          cnt_clear;

    arp_result_dispatch #(.NUM_QUEUES(NQ), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .arp_mac_vld(arp_mac_vld), .next_hop_mac(next_hop_mac),
        .output_port(output_port), .arp_lookup_hit(arp_lookup_hit),
        .lpm_lookup_hit(lpm_lookup_hit), .rd_arp_result(rd_arp_result), .src_vld(src_vld),
        .src_port(src_port), .rd_src(rd_src), .result_vld(result_vld),
        .result_rdy(result_rdy), .dst_mac(dst_mac), .dst_port(dst_port), .to_cpu(to_cpu),
        .drop(drop), .reason(reason), .lpm_miss_cnt(lpm_miss_cnt),
        .arp_miss_cnt(arp_miss_cnt), .cnt_clear(cnt_clear)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_pops  = 0;
    logic last_pop;
    logic m_vld;
    logic [CW-1:0] m_lpm, m_arp;
    dec_t cur_exp;
    dec_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic dec_t ref_decide(input logic lpm, input logic arp, input logic [7:0] op,
                                        input logic [47:0] mac, input logic [7:0] src);
        dec_t d;
        int idx;
        d   = '0;
        idx = -1;
        for (int i = 7; i >= 0; i--) if (src[i]) idx = i;
        if (lpm && arp) begin
            d.port = op;
            d.mac  = mac;
        end else if (idx >= 0 && (idx % 2) == 0) begin
            d.reason = lpm ? 2'b10 : 2'b01;
            d.port   = 8'(1 << (idx + 1));
            d.cpu    = 1'b1;
        end else begin
            d.reason = 2'b11;
            d.drop   = 1'b1;
        end
        return d;
    endfunction

    task automatic set_in(input logic lpm, input logic arp, input logic [7:0] op,
                          input logic [47:0] mac, input logic [7:0] src);
        lpm_lookup_hit = lpm;
        arp_lookup_hit = arp;
        output_port    = op;
        next_hop_mac   = mac;
        src_port       = src;
        cur_exp        = ref_decide(lpm, arp, op, mac, src);
    endtask

    task automatic model_reset();
        sb.delete();
        m_vld = 1'b0;
        m_lpm = '0;
        m_arp = '0;
    endtask

    // One clock: sample at the falling edge, compare, advance the model, return at posedge+1.
    task automatic step();
        logic exp_pop;
        logic [59:0] got;
        @(negedge clk);
        exp_pop = reset && arp_mac_vld && src_vld && (!m_vld || result_rdy);
        chk("rd_arp_result", 64'(rd_arp_result), 64'(exp_pop));
        chk("rd_src", 64'(rd_src), 64'(exp_pop));
        chk("result_vld", 64'(result_vld), 64'(m_vld));
        if (m_vld) begin
            got = {reason, dst_port, dst_mac, to_cpu, drop};
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL scoreboard: got decision %0h with nothing expected", got);
            end else begin
                chk("decision", 64'(got), 64'(sb[0]));
                if (result_rdy) void'(sb.pop_front());
            end
        end
        chk("lpm_miss_cnt", 64'(lpm_miss_cnt), 64'(m_lpm));
        chk("arp_miss_cnt", 64'(arp_miss_cnt), 64'(m_arp));
        last_pop = exp_pop;
        if (!reset) begin
            model_reset();
        end else begin
            if (exp_pop) begin
                sb.push_back(cur_exp);
                n_pops++;
                m_vld = 1'b1;
            end else if (result_rdy) begin
                m_vld = 1'b0;
            end
            if (cnt_clear) begin
                m_lpm = '0;
                m_arp = '0;
            end else if (exp_pop) begin
                if (!lpm_lookup_hit && m_lpm != '1) m_lpm = m_lpm + 1'b1;
                if (lpm_lookup_hit && !arp_lookup_hit && m_arp != '1) m_arp = m_arp + 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[10];
    logic [7:0] bp_src[3];
    int fifo_n;
    int pops0;

    initial begin
        vecs[0] = '{1, 1, 8'h04, 48'h0011_2233_4455, 8'h01, '{2'b00, 8'h04, 48'h0011_2233_4455, 0, 0}};
        vecs[1] = '{1, 0, 8'h10, 48'h1111_1111_1111, 8'h04, '{2'b10, 8'h08, 48'h0, 1, 0}};
        vecs[2] = '{0, 1, 8'h01, 48'h2222_2222_2222, 8'h02, '{2'b11, 8'h00, 48'h0, 0, 1}};
        vecs[3] = '{0, 1, 8'h01, 48'h3333_3333_3333, 8'h10, '{2'b01, 8'h20, 48'h0, 1, 0}};
        vecs[4] = '{1, 0, 8'h02, 48'h4444_4444_4444, 8'h40, '{2'b10, 8'h80, 48'h0, 1, 0}};
        vecs[5] = '{0, 0, 8'h02, 48'h5555_5555_5555, 8'h01, '{2'b01, 8'h02, 48'h0, 1, 0}};
        vecs[6] = '{1, 0, 8'h04, 48'h6666_6666_6666, 8'h00, '{2'b11, 8'h00, 48'h0, 0, 1}};
        vecs[7] = '{1, 0, 8'h04, 48'h7777_7777_7777, 8'h0C, '{2'b10, 8'h08, 48'h0, 1, 0}};
        vecs[8] = '{1, 0, 8'h04, 48'h8888_8888_8888, 8'h06, '{2'b11, 8'h00, 48'h0, 0, 1}};
        vecs[9] = '{1, 1, 8'h80, 48'hABCD_EF01_2345, 8'h20, '{2'b00, 8'h80, 48'hABCD_EF01_2345, 0, 0}};
        bp_src[0] = 8'h01; bp_src[1] = 8'h04; bp_src[2] = 8'h10;

        reset = 1'b0; cnt_clear = 1'b0; result_rdy = 1'b1;
        arp_mac_vld = 1'b1; src_vld = 1'b1;
        set_in(1, 1, 8'h04, 48'h0011_2233_4455, 8'h01);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result_vld", 64'(result_vld), 0);
        chk("reset_dst_mac", 64'(dst_mac), 0);
        chk("reset_dst_port", 64'(dst_port), 0);
        chk("reset_flags", 64'({to_cpu, drop, reason}), 0);
        chk("reset_rd", 64'({rd_arp_result, rd_src}), 0);
        step();
        arp_mac_vld = 1'b0; src_vld = 1'b0;
        reset = 1'b1;
        step();

        // Table vectors, back to back at one decision per cycle.
        arp_mac_vld = 1'b1; src_vld = 1'b1;
        foreach (vecs[i]) begin
            lpm_lookup_hit = vecs[i].lpm;
            arp_lookup_hit = vecs[i].arp;
            output_port    = vecs[i].op;
            next_hop_mac   = vecs[i].mac;
            src_port       = vecs[i].src;
            cur_exp        = vecs[i].exp;
            step();
        end
        arp_mac_vld = 1'b0; src_vld = 1'b0;
        step();

        // Back-pressure with three entries queued in both FIFOs.
        fifo_n = 3; pops0 = n_pops; result_rdy = 1'b0;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) result_rdy = 1'b1;
            arp_mac_vld = (fifo_n > 0); src_vld = (fifo_n > 0);
            if (fifo_n > 0) set_in(1, (fifo_n != 2), 8'h40, 48'hC0DE_0000_0000 + 48'(fifo_n), bp_src[3 - fifo_n]);
            step();
            if (last_pop) fifo_n--;
            if (c == 4) chk("bp_single_pop", 64'(n_pops - pops0), 1);
        end
        chk("bp_drained", 64'(n_pops - pops0), 3);
        arp_mac_vld = 1'b0; src_vld = 1'b0;
        step();

        // Saturation, then clear colliding with a miss.
        set_in(1, 0, 8'h01, 48'h0, 8'h04);
        arp_mac_vld = 1'b1; src_vld = 1'b1;
        repeat (18) step();
        chk("arp_saturated", 64'(arp_miss_cnt), 64'hF);
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        chk("arp_cleared", 64'(arp_miss_cnt), 0);
        arp_mac_vld = 1'b0; src_vld = 1'b0;
        step();

        // Join skew: ARP side ready four cycles before the source side.
        pops0 = n_pops;
        set_in(1, 1, 8'h04, 48'h0011_2233_4455, 8'h01);
        arp_mac_vld = 1'b1;
        repeat (4) step();
        chk("skew_no_pop", 64'(n_pops - pops0), 0);
        result_rdy = 1'b0;
        src_vld = 1'b1;
        step();
        chk("skew_pop", 64'(n_pops - pops0), 1);
        chk("vld_before_reset", 64'(result_vld), 1);

        // Async reset while a decision is held.
        reset = 1'b0;
        #1;
        chk("async_rst_vld", 64'(result_vld), 0);
        chk("async_rst_outs", 64'({dst_mac, dst_port, to_cpu, drop, reason}), 0);
        chk("async_rst_rd", 64'({rd_arp_result, rd_src}), 0);
        model_reset();
        step();
        reset = 1'b1; result_rdy = 1'b1;
        step();
        arp_mac_vld = 1'b0; src_vld = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
